// File: rtl/sync_stream_fifo_pkg.sv
// Shared types, defaults and sizing helpers for sync_stream_fifo.
package sync_stream_fifo_pkg;

  localparam int unsigned DEF_WIDTH             = 128;
  localparam int unsigned DEF_DEPTH             = 128;
  localparam int          DEF_PROG_FULL_MARGIN  = 12;
  localparam int          DEF_PROG_EMPTY_THRESH = 10;

  // Pointer carries one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Stored entry is {tlast, tdata}.
  function automatic int unsigned entry_w(input int unsigned width);
    return width + 1;
  endfunction

  typedef struct packed {
    logic                 tlast;
    logic [DEF_WIDTH-1:0] tdata;
  } entry_t;

endpackage

// File: rtl/sync_stream_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module sdp_ram
  import sync_stream_fifo_pkg::*;
#(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = entry_w(DEF_WIDTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port; output holds while re_i is low.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_stream_fifo.sv
// AXI-stream FIFO with first-word-fall-through output register.
// Define SYNC_STREAM_FIFO_PACKET_MODE_EN for store-and-forward packet mode.
module sync_stream_fifo
  import sync_stream_fifo_pkg::*;
#(
  parameter int unsigned WIDTH             = DEF_WIDTH,
  parameter int unsigned DEPTH             = DEF_DEPTH,
  parameter int          PROG_FULL_THRESH  = int'(DEPTH) - DEF_PROG_FULL_MARGIN,
  parameter int          PROG_EMPTY_THRESH = DEF_PROG_EMPTY_THRESH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [WIDTH-1:0]        s_axis_tdata,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_prog_full,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [WIDTH-1:0]        m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    m_axis_prog_empty,
  output logic [ptr_w(DEPTH)-1:0] count,
  output logic                    oversize_err
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam int unsigned EW = entry_w(WIDTH);
  localparam logic [PW-1:0] PF_T = PW'(PROG_FULL_THRESH);
  localparam logic [PW-1:0] PE_T = PW'(PROG_EMPTY_THRESH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] fetch_ptr_q, fetch_ptr_d, count_q, count_d;
  logic          rdy_q, rdy_d, pf_q, pf_d, pe_q, pe_d;
  logic          ram_vld_q, ram_vld_d, out_vld_q, out_vld_d;
  logic [EW-1:0] out_q, out_d, ram_rdata;
  logic          push, pop, full_d, avail, re, out_load;

  // Write/occupancy side: rd_ptr frees a slot only when the consumer takes the word.
  always_comb begin
    push     = s_axis_tvalid && rdy_q;
    pop      = out_vld_q && m_axis_tready;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + PW'(push) - PW'(pop);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    rdy_d    = !full_d;
    pf_d     = (count_q >= PF_T);
    pe_d     = (count_q <= PE_T);
  end

`ifdef SYNC_STREAM_FIFO_PACKET_MODE_EN
  logic [PW-1:0] commit_q, commit_d;
  logic          cut_q, cut_d, err_q, err_d;

  // Commit on tlast; a full FIFO with nothing committed forces a cut-through commit.
  // Fetch may use commit_d because words already in RAM are safe to read this edge.
  always_comb begin
    commit_d = commit_q;
    cut_d    = cut_q;
    err_d    = err_q;
    if (push && (s_axis_tlast || cut_q)) commit_d = wr_ptr_d;
    if (push) cut_d = cut_q && !s_axis_tlast;
    if (full_d && (commit_d == rd_ptr_d)) begin
      commit_d = wr_ptr_d;
      cut_d    = 1'b1;
      err_d    = 1'b1;
    end
    avail = (fetch_ptr_q != commit_d) && (fetch_ptr_q != wr_ptr_q);
  end

  // Packet-mode state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_q <= '0;
      cut_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      commit_q <= commit_d;
      cut_q    <= cut_d;
      err_q    <= err_d;
    end
  end

  assign oversize_err = err_q;
`else
  // Every written word is visible to the read side.
  always_comb begin
    avail = (fetch_ptr_q != wr_ptr_q);
  end

  assign oversize_err = 1'b0;
`endif

  // Read pipeline: RAM read register feeds the output register; both stall independently.
  always_comb begin
    out_load    = ram_vld_q && (!out_vld_q || m_axis_tready);
    re          = (!ram_vld_q || out_load) && avail;
    fetch_ptr_d = fetch_ptr_q + PW'(re);
    ram_vld_d   = re || (ram_vld_q && !out_load);
    out_vld_d   = out_load || (out_vld_q && !m_axis_tready);
    out_d       = out_load ? ram_rdata : out_q;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fetch_ptr_q <= '0;
      count_q     <= '0;
      rdy_q       <= 1'b0;
      pf_q        <= 1'b0;
      pe_q        <= 1'b1;
      ram_vld_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fetch_ptr_q <= fetch_ptr_d;
      count_q     <= count_d;
      rdy_q       <= rdy_d;
      pf_q        <= pf_d;
      pe_q        <= pe_d;
      ram_vld_q   <= ram_vld_d;
      out_vld_q   <= out_vld_d;
      out_q       <= out_d;
    end
  end

  sdp_ram #(
    .AW (AW),
    .DW (EW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i ({s_axis_tlast, s_axis_tdata}),
    .re_i    (re),
    .raddr_i (fetch_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign s_axis_tready     = rdy_q;
  assign s_axis_prog_full  = pf_q;
  assign m_axis_prog_empty = pe_q;
  assign m_axis_tvalid     = out_vld_q;
  assign m_axis_tdata      = out_q[WIDTH-1:0];
  assign m_axis_tlast      = out_q[WIDTH];
  assign count             = count_q;

endmodule

// File: tb/tb_sync_stream_fifo.sv
// Self-checking bench for sync_stream_fifo (DEPTH=16, WIDTH=16).
// Packet-mode scenarios build when SYNC_STREAM_FIFO_PACKET_MODE_EN is defined.
module tb_sync_stream_fifo;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int PF = D - 12;
  localparam int PE = 10;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_tvalid, s_tready, s_tlast, pf;
  logic          m_tvalid, m_tready, m_tlast, pe, oerr;
  logic [W-1:0]  s_tdata, m_tdata;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;
  logic [W:0] sb[$];
  int   model_cnt = 0;
  int   prev_cnt  = 0;
  int   n_out     = 0;
  logic mon_en    = 1'b0;
  logic hold_pend = 1'b0;
  logic [W:0] hold_word = '0;

  always #5 clk = ~clk;

  sync_stream_fifo #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tready     (s_tready),
    .s_axis_tdata      (s_tdata),
    .s_axis_tlast      (s_tlast),
    .s_axis_prog_full  (pf),
    .m_axis_tvalid     (m_tvalid),
    .m_axis_tready     (m_tready),
    .m_axis_tdata      (m_tdata),
    .m_axis_tlast      (m_tlast),
    .m_axis_prog_empty (pe),
    .count             (count),
    .oversize_err      (oerr)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard and occupancy model, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 64'(count), 64'(model_cnt));
      chk("s_tready", 64'(s_tready), 64'(model_cnt != D));
      chk("prog_full", 64'(pf), 64'(prev_cnt >= PF));
      chk("prog_empty", 64'(pe), 64'(prev_cnt <= PE));
      if (hold_pend) begin
        chk("hold_valid", 64'(m_tvalid), 64'(1));
        chk("hold_word", 64'({m_tlast, m_tdata}), 64'(hold_word));
      end
      prev_cnt = model_cnt;
      if (s_tvalid && s_tready) begin
        sb.push_back({s_tlast, s_tdata});
        model_cnt++;
      end
      if (m_tvalid && m_tready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) chk("out_word", 64'({m_tlast, m_tdata}), 64'(sb.pop_front()));
        model_cnt--;
        n_out++;
      end
      hold_pend = m_tvalid && !m_tready;
      hold_word = {m_tlast, m_tdata};
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'(0));
    chk({tag, "_s_tready"}, 64'(s_tready), 64'(0));
    chk({tag, "_prog_full"}, 64'(pf), 64'(0));
    chk({tag, "_prog_empty"}, 64'(pe), 64'(1));
    chk({tag, "_count"}, 64'(count), 64'(0));
    chk({tag, "_oversize"}, 64'(oerr), 64'(0));
    chk({tag, "_tdata"}, 64'(m_tdata), 64'(0));
    chk({tag, "_tlast"}, 64'(m_tlast), 64'(0));
  endtask

  // Holds the word until accepted; returns #1 after the accepting edge.
  task automatic push_word(input logic [W-1:0] d, input logic last);
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_tready) begin
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        return;
      end
    end
    chk("push_timeout", 64'(s_tready), 64'(1));
    s_tvalid = 1'b0;
  endtask

  task automatic wait_out(input int target);
    for (int t = 0; t < 500 && n_out < target; t++) begin
      @(posedge clk);
      #1;
    end
    chk("out_words", 64'(n_out), 64'(target));
  endtask

  task automatic wait_empty();
    for (int t = 0; t < 200 && (count != 0 || m_tvalid); t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_count", 64'(count), 64'(0));
  endtask

  task automatic release_reset();
    rst = 1'b0;
    #1;
    chk("tready_before_edge", 64'(s_tready), 64'(0));
    @(posedge clk);
    #1;
    chk("tready_after_edge", 64'(s_tready), 64'(1));
    hold_pend = 1'b0;
    mon_en    = 1'b1;
  endtask

  initial begin
    int base;
    int idx;
    logic acc;
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    release_reset();

    // Single word: visible two edges after the write edge, count 0->1->0.
    m_tready = 1'b1;
    s_tdata  = 16'h00A5;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    chk("s1_count_e0", 64'(count), 64'(1));
    chk("s1_valid_e0", 64'(m_tvalid), 64'(0));
    @(posedge clk); #1;
    chk("s1_valid_e1", 64'(m_tvalid), 64'(0));
    @(posedge clk); #1;
    chk("s1_valid_e2", 64'(m_tvalid), 64'(1));
    chk("s1_data", 64'(m_tdata), 64'(16'h00A5));
    chk("s1_last", 64'(m_tlast), 64'(1));
    chk("s1_count_e2", 64'(count), 64'(1));
    @(posedge clk); #1;
    chk("s1_valid_e3", 64'(m_tvalid), 64'(0));
    chk("s1_count_e3", 64'(count), 64'(0));

    // Fill to DEPTH with the consumer stalled.
    m_tready = 1'b0;
    for (int i = 0; i < D; i++) begin
      push_word(W'(16'h0100 + i), 1'b1);
      chk("fill_count", 64'(count), 64'(i + 1));
      chk("fill_prog_full", 64'(pf), 64'(i >= PF));
    end
    chk("fill_tready", 64'(s_tready), 64'(0));
    chk("fill_count_full", 64'(count), 64'(D));

    // Push and pop together at full: push refused, tready returns next cycle.
    s_tdata  = 16'h01FF;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    chk("fullpop_count", 64'(count), 64'(D - 1));
    chk("fullpop_tready", 64'(s_tready), 64'(1));
    wait_empty();

    // Incrementing stream with random backpressure on both sides.
    base = n_out;
    idx  = 0;
    for (int cyc = 0; cyc < 3000 && (n_out - base) < 3 * D; cyc++) begin
      if (idx < 3 * D) begin
        s_tvalid = ($urandom_range(0, 3) != 0);
        s_tdata  = W'(16'h0200 + idx);
        s_tlast  = ((idx % 5) == 4) || (idx == 3 * D - 1);
      end else begin
        s_tvalid = 1'b0;
      end
      m_tready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = s_tvalid && s_tready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    s_tvalid = 1'b0;
    chk("stream_in", 64'(idx), 64'(3 * D));
    chk("stream_out", 64'(n_out - base), 64'(3 * D));
    m_tready = 1'b1;
    wait_empty();

`ifdef SYNC_STREAM_FIFO_PACKET_MODE_EN
    // Store-and-forward: nothing visible until one edge after the tlast push.
    m_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_word(W'(16'h0300 + k), k == 3);
      chk("pk_gap_valid", 64'(m_tvalid), 64'(0));
      if (k < 3) begin
        repeat (2) begin
          @(posedge clk); #1;
          chk("pk_gap_valid", 64'(m_tvalid), 64'(0));
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("pk_valid", 64'(m_tvalid), 64'(1));
      chk("pk_data", 64'(m_tdata), 64'(16'h0300 + k));
      chk("pk_last", 64'(m_tlast), 64'(k == 3));
    end
    @(posedge clk); #1;
    chk("pk_end_valid", 64'(m_tvalid), 64'(0));

    // Oversize packet: flag on the 16th word, all 20 words delivered.
    base = n_out;
    for (int k = 0; k < 20; k++) begin
      push_word(W'(16'h0400 + k), k == 19);
      chk("ovf_err", 64'(oerr), 64'(k >= D - 1));
    end
    wait_out(base + 20);
    wait_empty();
    chk("ovf_sticky", 64'(oerr), 64'(1));
`endif

    // Reset mid-packet with a handshake pending.
    m_tready = 1'b0;
    push_word(16'h0500, 1'b0);
    push_word(16'h0501, 1'b0);
    s_tdata  = 16'h0502;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    mon_en   = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset("rst_async");
    sb.delete();
    model_cnt = 0;
    prev_cnt  = 0;
    s_tvalid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_hold");
    release_reset();
    m_tready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("post_rst_valid", 64'(m_tvalid), 64'(0));
    end
    chk("post_rst_count", 64'(count), 64'(0));
    chk("sb_empty_end", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/sync_stream_fifo.md
SYNC_STREAM_FIFO -- requirements
Module: sync_stream_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as follows:
- clk  input  1  the only clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.

REQ-002 The block SHALL have the following parameters:
- WIDTH, 128, tdata width in bits.
- DEPTH, 128, storage words; must be a power of 2 and at least 4.
- PROG_FULL_THRESH, DEPTH-12, prog_full assertion level in words.
- PROG_EMPTY_THRESH, 10, prog_empty assertion level in words.

REQ-003 The block SHALL have the following ports, in addition to clk and rst:
- s_axis_tvalid  input  1  upstream word valid.
- s_axis_tready  output  1  FIFO can accept a word.
- s_axis_tdata  input  WIDTH  upstream data.
- s_axis_tlast  input  1  last word of packet.
- s_axis_prog_full  output  1  occupancy at or above PROG_FULL_THRESH.
- m_axis_tvalid  output  1  downstream word valid.
- m_axis_tready  input  1  downstream accepts.
- m_axis_tdata  output  WIDTH  downstream data.
- m_axis_tlast  output  1  last word of packet.
- m_axis_prog_empty  output  1  occupancy at or below PROG_EMPTY_THRESH.
- count  output  $clog2(DEPTH)+1  words held, including the output register.
- oversize_err  output  1  sticky flag; packet-mode oversize event.

Function
REQ-004 A transfer SHALL occur on either side only in a cycle where tvalid and tready are both high.
- Once m_axis_tvalid is raised, it and its tdata/tlast SHALL hold until accepted.

REQ-005 Storage SHALL be DEPTH words of {tlast, tdata}.
- Write and read pointers SHALL be $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
- full = pointers equal except the MSB; empty = pointers fully equal.

REQ-006 s_axis_tready SHALL equal NOT full, taken from registered state only.
- There SHALL be no combinational path from m_axis_tready to s_axis_tready.
- A push is therefore refused when the FIFO is full, even if a pop occurs in the same cycle.

REQ-007 The output SHALL be first-word-fall-through through one output register.
- A word written into an empty FIFO SHALL appear on m_axis_tvalid 2 cycles after the write edge.
- Back-to-back reads SHALL sustain one word per cycle.

REQ-008 Simultaneous push and pop SHALL leave count unchanged.
- This includes the cycle at empty in which the output register is being refilled.

REQ-009 count SHALL be exact in every cycle.
- s_axis_prog_full and m_axis_prog_empty SHALL be registered.
- Both SHALL reflect count as of the previous edge (1-cycle lag).

REQ-010 Pointer wrap-around SHALL be seamless: no bubble and no data corruption across the DEPTH boundary.

Reset
REQ-011 While rst is high, and asynchronously on its assertion, the block SHALL be held in the following state:
- pointers 0, count 0;
- m_axis_tvalid 0, s_axis_tready 0;
- s_axis_prog_full 0, m_axis_prog_empty 1;
- oversize_err 0, m_axis_tdata/tlast 0.

REQ-012 s_axis_tready SHALL rise on the first edge after rst is deasserted.

REQ-013 A reset asserted mid-packet or mid-handshake SHALL discard all stored and in-flight words, with no partial packet emitted afterwards.

Configuration
REQ-014 Macro SYNC_STREAM_FIFO_PACKET_MODE_EN SHALL compile in store-and-forward packet mode.
- A committed write pointer SHALL advance only on the push of a word with tlast=1.
- The read side SHALL see only committed words, so m_axis_tvalid rises only once a whole packet is stored.

REQ-015 In packet mode, if the FIFO becomes full with no committed packet, the block SHALL do the following:
- commit the partial packet immediately;
- set oversize_err, which stays set until reset;
- stream the rest of that packet cut-through.

REQ-016 Without the macro, every pushed word SHALL be immediately visible to the read side and oversize_err SHALL be tied 0.

Structure
REQ-017 The package sync_stream_fifo_pkg SHALL hold the following:
- the entry typedef (struct of tlast and tdata, width-parameterised via a function or localparam);
- the pointer-width helper function;
- the default threshold constants.

REQ-018 Storage SHALL be a separate sub-module, sdp_ram: simple dual-port, one write port, one registered read port, same clk.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Single push of 0xA5 with tlast=1, m_axis_tready=1 -> m_axis_tvalid high exactly 2 cycles later with data 0xA5; count goes 0->1->0.
- Fill with m_axis_tready=0 for DEPTH=16 -> s_axis_tready low after 16 pushes; prog_full high one cycle after count reaches PROG_FULL_THRESH; count=16.
- Full FIFO, s_axis_tvalid=1 and m_axis_tready=1 together -> push refused that cycle, count=15, and s_axis_tready high on the next cycle.
- Stream 3*DEPTH incrementing words with random backpressure on both sides -> output sequence identical, no loss or duplication across wraps.
- Packet mode: 4-word packet with 2-cycle gaps -> m_axis_tvalid stays 0 until 1 cycle after the tlast push, then emits 4 contiguous words.
- Packet mode with DEPTH=16: 20-word packet -> oversize_err=1 after the 16th word, all 20 words delivered in order; then rst mid-packet -> all outputs return to their reset values and the FIFO is empty.
